ma_stage: RTL

Memory-access stage of the five-stage RISC pipeline. Sits directly downstream of the EX/MA pipeline register and consumes its Result, Inst, Operand_B and Inst_Type outputs. Performs RV32I loads and stores against a private data memory with configurable access latency, stalling upstream while busy. Drives the MA/RW pipeline register contents consumed by write-back and the register file.

---
 rtl/rv_pipe_pkg.sv | 56 +++++
 rtl/ma_dmem.sv | 41 ++++
 rtl/ma_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pipe_pkg
//  Description : Shared pipeline codes, load/store width helpers, MA FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

   localparam logic [4:0] ITYPE_ALU    = 5'd0;
   localparam logic [4:0] ITYPE_LOAD   = 5'd1;
   localparam logic [4:0] ITYPE_STORE  = 5'd2;
   localparam logic [4:0] ITYPE_BRANCH = 5'd3;
   localparam logic [4:0] ITYPE_JUMP   = 5'd4;
   localparam logic [4:0] ITYPE_LUI    = 5'd5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      WIDTH_B = 2'd0,
      WIDTH_H = 2'd1,
      WIDTH_W = 2'd2
   } mem_width_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } ma_state_e;

   // Unrecognised funct3 encodings fall back to full-word access.
   function automatic mem_width_e decode_width(input logic is_store, input logic [2:0] funct3);
      mem_width_e w;
      w = WIDTH_W;
      if (is_store) begin
         if (funct3 == F3_B)      w = WIDTH_B;
         else if (funct3 == F3_H) w = WIDTH_H;
      end else begin
         if (funct3 == F3_B || funct3 == F3_BU)      w = WIDTH_B;
         else if (funct3 == F3_H || funct3 == F3_HU) w = WIDTH_H;
      end
      return w;
   endfunction

   function automatic logic is_misaligned(input mem_width_e w, input logic [1:0] lane);
      logic m;
      m = 1'b0;
      if (w == WIDTH_H)      m = lane[0];
      else if (w == WIDTH_W) m = (lane != 2'b00);
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ma_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : ma_dmem
//  Description : Single-port data RAM, 4 byte enables, read-before-write
//  Revision    : 1.0 - initial release
// ============================================================================
module ma_dmem #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   // Array contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_rdata <= 32'h0;
      else if (rd_en) r_rdata <= r_mem[addr];
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ma_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ma_stage
//  Description : Memory-access pipeline stage with multi-cycle private DMEM
//  Revision    : 1.0 - initial release
// ============================================================================
module ma_stage
   import rv_pipe_pkg::*;
#(
   parameter int DMEM_DEPTH  = 1024,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Valid_In,
   input  logic [31:0] Result_In,
   input  logic [31:0] Inst_In,
   input  logic [31:0] Operand_B_In,
   input  logic [4:0]  Inst_Type_In,
   output logic        Stall_Out,
   output logic        Valid_Out,
   output logic [31:0] Result_Out,
   output logic [31:0] Ld_Data_Out,
   output logic [31:0] Inst_Out,
   output logic [4:0]  Inst_Type_Out,
   output logic [4:0]  RD_Addr_Out,
   output logic        Reg_Write_flag_Out,
   output logic        Misalign_Out
);

   localparam int              ADDR_W        = $clog2(DMEM_DEPTH);
   localparam int              CNT_W         = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] C_BUSY_CYCLES = CNT_W'(MEM_LATENCY - 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST    = CNT_W'(1);
   localparam logic             C_MULTI_CYCLE = (MEM_LATENCY >= 2);

   ma_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hold_result;
   logic [31:0]      r_hold_inst;
   logic [31:0]      r_hold_opb;
   logic [4:0]       r_hold_type;

   logic             r_ld_valid;
   logic             r_ld_signed;
   mem_width_e       r_ld_width;
   logic [1:0]       r_ld_lane;

   logic             w_busy;
   logic [31:0]      w_result;
   logic [31:0]      w_inst;
   logic [31:0]      w_opb;
   logic [4:0]       w_type;
   logic             w_is_load;
   logic             w_is_store;
   mem_width_e       w_width;
   logic [1:0]       w_lane;
   logic             w_misalign;
   logic             w_accept;
   logic             w_go_busy;
   logic             w_retire;
   logic             w_access;
   logic             w_reg_write;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_rdata;
   logic [31:0]      w_shifted;
   logic [31:0]      w_ld_data;

   assign w_busy    = (r_state == ST_BUSY);
   assign Stall_Out = w_busy;

   // While BUSY the access is driven from the latched copy; upstream is frozen.
   assign w_result   = w_busy ? r_hold_result : Result_In;
   assign w_inst     = w_busy ? r_hold_inst   : Inst_In;
   assign w_opb      = w_busy ? r_hold_opb    : Operand_B_In;
   assign w_type     = w_busy ? r_hold_type   : Inst_Type_In;

   assign w_is_load  = (w_type == ITYPE_LOAD);
   assign w_is_store = (w_type == ITYPE_STORE);
   assign w_width    = decode_width(w_is_store, w_inst[14:12]);
   assign w_lane     = w_result[1:0];
   assign w_misalign = (w_is_load | w_is_store) & is_misaligned(w_width, w_lane);

   assign w_accept   = ~w_busy & Valid_In;
   assign w_go_busy  = w_accept & (w_is_load | w_is_store) & ~w_misalign & C_MULTI_CYCLE;
   assign w_retire   = (w_accept & ~w_go_busy) | (w_busy & (r_cnt == C_CNT_LAST));
   assign w_access   = w_retire & ~w_misalign;

   assign w_reg_write = w_retire & (w_type != ITYPE_STORE) & (w_type != ITYPE_BRANCH)
                        & ~w_misalign & (w_inst[11:7] != 5'd0);

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = w_opb;
      case (w_width)
         WIDTH_B: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{w_opb[7:0]}};
         end
         WIDTH_H: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{w_opb[15:0]}};
         end
         default: ;
      endcase
   end

   ma_dmem #(
      .DEPTH  (DMEM_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk   (clk),
      .rst_n (rst_n),
      .rd_en (w_access & w_is_load),
      .wr_en (w_access & w_is_store),
      .be    (w_be),
      .addr  (w_result[ADDR_W+1:2]),
      .wdata (w_wdata),
      .rdata (w_rdata)
   );

   // Extension runs on the RAM's output register, so the load result is held
   // alongside the other retired fields.
   assign w_shifted = w_rdata >> {r_ld_lane, 3'b000};

   always_comb begin
      w_ld_data = 32'h0;
      if (r_ld_valid) begin
         case (r_ld_width)
            WIDTH_B: w_ld_data = {{24{r_ld_signed & w_shifted[7]}},  w_shifted[7:0]};
            WIDTH_H: w_ld_data = {{16{r_ld_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_ld_data = w_rdata;
         endcase
      end
   end

   assign Ld_Data_Out = w_ld_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state            <= ST_IDLE;
         r_cnt              <= '0;
         r_hold_result      <= 32'h0;
         r_hold_inst        <= 32'h0;
         r_hold_opb         <= 32'h0;
         r_hold_type        <= 5'd0;
         r_ld_valid         <= 1'b0;
         r_ld_signed        <= 1'b0;
         r_ld_width         <= WIDTH_W;
         r_ld_lane          <= 2'b00;
         Valid_Out          <= 1'b0;
         Result_Out         <= 32'h0;
         Inst_Out           <= 32'h0;
         Inst_Type_Out      <= 5'd0;
         RD_Addr_Out        <= 5'd0;
         Reg_Write_flag_Out <= 1'b0;
         Misalign_Out       <= 1'b0;
      end else begin
         Valid_Out <= w_retire;
         case (r_state)
            ST_IDLE: begin
               if (w_go_busy) begin
                  r_state       <= ST_BUSY;
                  r_cnt         <= C_BUSY_CYCLES;
                  r_hold_result <= Result_In;
                  r_hold_inst   <= Inst_In;
                  r_hold_opb    <= Operand_B_In;
                  r_hold_type   <= Inst_Type_In;
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt - C_CNT_LAST;
               if (r_cnt == C_CNT_LAST) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         if (w_retire) begin
            Result_Out         <= w_result;
            Inst_Out           <= w_inst;
            Inst_Type_Out      <= w_type;
            RD_Addr_Out        <= w_inst[11:7];
            Reg_Write_flag_Out <= w_reg_write;
            Misalign_Out       <= w_misalign;
            r_ld_valid         <= w_is_load & ~w_misalign;
            r_ld_signed        <= ~w_inst[14];
            r_ld_width         <= w_width;
            r_ld_lane          <= w_lane;
         end
      end
   end

endmodule
`default_nettype wire
